// File: rtl/dmem_arb_pkg.sv
// Shared constants, bus payload type and address-check helper for dmem_arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_NREQ      = 2;
  localparam int unsigned DEF_MAX_LOCK  = 4;
  localparam int unsigned DEF_MEM_BYTES = 1024;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned IDX_W         = $clog2(DEF_NREQ);

  // One requester's memory access as presented to the data memory.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // True when a word access is misaligned or runs past the last full word.
  function automatic logic range_err(input logic [ADDR_W-1:0] a, input int unsigned mem_bytes);
    return (a[1:0] != 2'b00) || (a > ADDR_W'(mem_bytes - WORD_BYTES));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (packed per requester, 32 bits each).
interface dmem_arb_if #(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ-1:0]    lock;
  logic [NREQ*32-1:0] addr;
  logic [NREQ*32-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [31:0]        rdata;
  logic [NREQ-1:0]    err;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first request above ptr (wrapping), skipping excl.
module rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [NREQ-1:0]  excl,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan ptr+1 .. ptr+NREQ modulo NREQ, first eligible request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= int'(NREQ); off++) begin
      int j;
      j = (int'(ptr) + off) % int'(NREQ);
      if (!any && req[IDX_W'(j)] && !excl[IDX_W'(j)]) begin
        any              = 1'b1;
        gnt[IDX_W'(j)]   = 1'b1;
        idx              = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin per cycle with bounded lock, 1-cycle registered read return.
// Optional macro RANGE_CHECK_EN: misaligned/out-of-range accesses are suppressed and flagged on err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned MAX_LOCK  = DEF_MAX_LOCK
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arb_if.slave   bus,
  output logic        mem_memwrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned NI    = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
`ifdef RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic [NI-1:0]    rr_ptr, rr_nxt;
  logic [NI-1:0]    owner, owner_nxt;
  logic             owner_valid, ov_nxt;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt;
  logic [NREQ-1:0]  rvalid_q, rvalid_nxt;
  logic [NREQ-1:0]  err_q, err_nxt;
  logic [31:0]      rdata_q, rdata_nxt;

  logic [NREQ-1:0]  owner_oh, excl, pick_gnt, win_oh;
  logic [NI-1:0]    pick_idx, win_idx;
  logic             pick_any, win_any, hold, others, bad;
  mem_req_t         sel;

  rr_pick #(.NREQ(NREQ), .IDX_W(NI)) u_pick (
    .req  (bus.req),
    .ptr  (rr_ptr),
    .excl (excl),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Winner selection: locked owner holds until its budget is spent, then yields once to others.
  always_comb begin
    owner_oh = NREQ'(1) << owner;
    hold     = owner_valid && bus.req[owner] && (lock_cnt < MAX_CNT);
    others   = |(bus.req & ~owner_oh);
    excl     = (owner_valid && (lock_cnt >= MAX_CNT) && others) ? owner_oh : '0;
    win_any  = hold || pick_any;
    win_idx  = hold ? owner : pick_idx;
    win_oh   = hold ? owner_oh : pick_gnt;
    sel      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_oh[i]) begin
        sel.we    = bus.we[i];
        sel.addr  = bus.addr[i*32 +: 32];
        sel.wdata = bus.wdata[i*32 +: 32];
      end
    end
    bad            = RANGE_EN && win_any && range_err(sel.addr, MEM_BYTES);
    mem_memwrite   = win_any && sel.we && !bad;
    mem_address    = (win_any && !bad) ? sel.addr : '0;
    mem_write_data = win_any ? sel.wdata : '0;
  end

  // Next state for pointer, lock ownership and the read-return registers.
  always_comb begin
    rr_nxt     = rr_ptr;
    owner_nxt  = owner;
    ov_nxt     = owner_valid;
    cnt_nxt    = lock_cnt;
    rvalid_nxt = '0;
    err_nxt    = '0;
    rdata_nxt  = rdata_q;
    if (win_any) begin
      rr_nxt = win_idx;
      if (|(bus.lock & win_oh)) begin
        owner_nxt = win_idx;
        ov_nxt    = 1'b1;
        if (owner_valid && (owner == win_idx))
          cnt_nxt = (lock_cnt < MAX_CNT) ? lock_cnt + CNT_W'(1) : lock_cnt;
        else
          cnt_nxt = CNT_W'(1);
      end else begin
        ov_nxt  = 1'b0;
        cnt_nxt = '0;
      end
      if (!sel.we) begin
        rvalid_nxt = win_oh;
        rdata_nxt  = bad ? 32'h0 : mem_read_data;
      end
      err_nxt = bad ? win_oh : '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= NI'(NREQ - 1);
      owner       <= '0;
      owner_valid <= 1'b0;
      lock_cnt    <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      rr_ptr      <= rr_nxt;
      owner       <= owner_nxt;
      owner_valid <= ov_nxt;
      lock_cnt    <= cnt_nxt;
      rvalid_q    <= rvalid_nxt;
      err_q       <= err_nxt;
      rdata_q     <= rdata_nxt;
    end
  end

  assign bus.gnt    = win_oh;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule
